// File: rtl/mult4_seq_pkg.sv
// Shared constants for the 4-bit sequential multiplier: operand width,
// iteration count and FSM state encodings.
package mult4_seq_pkg;

    localparam int MULT_WIDTH = 4;
    localparam int ITER_COUNT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult4_seq_addition4bit.sv
// 4-bit ripple-carry adder built from a chain of full-adder cells.
module Addition4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = cin;

    // Each bit is a full adder whose carry feeds the next stage.
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[4];

endmodule

// File: rtl/mult4_seq.sv
// Shift-and-add 4x4 unsigned multiplier: one partial product per RUN cycle,
// result registered into P with a one-cycle done pulse. WIDTH must stay 4.
module mult4_seq
    import mult4_seq_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplr;
    logic [WIDTH-1:0] acc_hi;
    logic [1:0]       cnt;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout;

    assign addend = mplr[0] ? mcand : '0;

    Addition4bit u_add (
        .a    (acc_hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // The adder result and multiplier shift right together each RUN cycle,
    // so after the last iteration {acc_hi, mplr} is the full product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            P      <= '0;
            mcand  <= '0;
            mplr   <= '0;
            acc_hi <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= A;
                        mplr   <= B;
                        acc_hi <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc_hi <= {cout, sum[WIDTH-1:1]};
                    mplr   <= {sum[0], mplr[WIDTH-1:1]};
                    cnt    <= cnt + 2'd1;
                    if (cnt == 2'(ITER_COUNT - 1)) begin
                        P     <= {cout, sum, mplr[WIDTH-1:1]};
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult4_seq.sv
// Directed self-checking bench for mult4_seq: latency, start handling,
// back-to-back operation, asynchronous reset and an exhaustive operand sweep.
module tb_mult4_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [7:0] P;

    int         tests_run;
    int         tests_failed;
    logic [7:0] exp_p;

    mult4_seq #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic st);
        A     = a;
        B     = b;
        start = st;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after k+5.
    task automatic runOp(input logic [3:0] a, input logic [3:0] b, input logic [7:0] expv, input string tag);
        applyStimulus(a, b, 1'b1);
        @(negedge clk);
        applyStimulus(4'h0, 4'h0, 1'b0);
        checkOutput({tag, " busy@k"}, busy, 1);
        checkOutput({tag, " done@k"}, done, 0);
        checkOutput({tag, " P held@k"}, P, exp_p);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checkOutput({tag, " busy run"}, busy, 1);
            checkOutput({tag, " done run"}, done, 0);
            checkOutput({tag, " P held run"}, P, exp_p);
        end
        @(negedge clk);
        checkOutput({tag, " done@k+4"}, done, 1);
        checkOutput({tag, " busy@k+4"}, busy, 1);
        checkOutput({tag, " P@k+4"}, P, expv);
        exp_p = expv;
        @(negedge clk);
        checkOutput({tag, " done@k+5"}, done, 0);
        checkOutput({tag, " busy@k+5"}, busy, 0);
        checkOutput({tag, " P@k+5"}, P, expv);
    endtask

    initial begin
        logic [3:0] pa [3];
        logic [3:0] pb [3];
        logic [7:0] pp [3];
        int         cyc;
        int         last;
        int         dones;
        logic       found;

        tests_run    = 0;
        tests_failed = 0;
        exp_p        = 8'd0;
        rst_n        = 1'b0;
        applyStimulus(4'h0, 4'h0, 1'b0);

        repeat (2) @(negedge clk);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset P", P, 0);

        // Start is raised together with reset release.
        rst_n = 1'b1;
        runOp(4'd15, 4'd15, 8'd225, "15x15");
        @(negedge clk);
        checkOutput("15x15 P held", P, 225);
        checkOutput("15x15 done low", done, 0);

        runOp(4'd0, 4'd9, 8'd0, "0x9");
        runOp(4'd9, 4'd1, 8'd9, "9x1");
        runOp(4'd1, 4'd9, 8'd9, "1x9");

        // Start pulsed mid-RUN must be ignored.
        applyStimulus(4'd7, 4'd6, 1'b1);
        @(negedge clk);
        applyStimulus(4'd0, 4'd0, 1'b0);
        checkOutput("7x6 busy@k", busy, 1);
        @(negedge clk);
        applyStimulus(4'd3, 4'd3, 1'b1);
        @(negedge clk);
        applyStimulus(4'd0, 4'd0, 1'b0);
        dones = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                checkOutput("7x6 P at done", P, 42);
            end
        end
        checkOutput("7x6 done count", dones, 1);
        checkOutput("7x6 P held", P, 42);
        checkOutput("7x6 idle", busy, 0);

        // Start held high: one result every 6 cycles.
        pa[0] = 4'd5;  pb[0] = 4'd5;  pp[0] = 8'd25;
        pa[1] = 4'd12; pb[1] = 4'd11; pp[1] = 8'd132;
        pa[2] = 4'd2;  pb[2] = 4'd8;  pp[2] = 8'd16;
        applyStimulus(pa[0], pb[0], 1'b1);
        cyc  = 0;
        last = 0;
        for (int op = 0; op < 3; op++) begin
            found = 1'b0;
            for (int t = 0; t < 20 && !found; t++) begin
                @(negedge clk);
                cyc++;
                if (done) found = 1'b1;
            end
            checkOutput("b2b done seen", found, 1);
            checkOutput("b2b P", P, pp[op]);
            if (op > 0) checkOutput("b2b interval", cyc - last, 6);
            last = cyc;
            if (op < 2) applyStimulus(pa[op + 1], pb[op + 1], 1'b1);
            else        applyStimulus(4'd0, 4'd0, 1'b0);
        end
        @(negedge clk);
        checkOutput("b2b idle", busy, 0);
        exp_p = 8'd16;

        // Asynchronous reset at the second RUN edge of 13x13.
        applyStimulus(4'd13, 4'd13, 1'b1);
        @(negedge clk);
        applyStimulus(4'd0, 4'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst busy async", busy, 0);
        checkOutput("rst P async", P, 0);
        checkOutput("rst done async", done, 0);
        exp_p = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("rst no done", dones, 0);
        checkOutput("rst P stays 0", P, 0);
        runOp(4'd3, 4'd4, 8'd12, "3x4");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                runOp(4'(a), 4'(b), 8'(a * b), "sweep");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
